judge3_vote: RTL and testbench
==============================

Name: judge3_vote

Overview:
- Registered three-voter majority ("2-of-3") judge.
- Samples three single-bit votes a, b, c every clock and registers the verdict `out`.
- Also registers side information: vote tally, unanimity flag, one-hot dissenter and a saturating pass counter.
- Used wherever a 2-of-3 decision on redundant signals is needed.

Parameters:
- CNT_W, 8: width of the pass counter pass_cnt (minimum 1).

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- en  input  1  sample enable; when 0 all registered outputs hold.
- a  input  1  vote of voter A (1 = yes).
- b  input  1  vote of voter B.
- c  input  1  vote of voter C.
- out  output  1  registered majority verdict.
- votes  output  2  registered count of yes votes (0..3).
- unanimous  output  1  registered; 1 when a == b == c.
- dissent  output  3  registered one-hot minority voter: bit2 = A, bit1 = B, bit0 = C.
- pass_cnt  output  CNT_W  registered count of enabled cycles with verdict 1; saturating.

Behaviour:
- Reset:
  - Rising clk with rst = 1 sets out = 0, votes = 0, unanimous = 0, dissent = 3'b000, pass_cnt = 0.
  - rst has priority over en.
  - rst asserted mid-operation clears everything on that edge; no partial state survives.
- Latency: 1 cycle. Inputs sampled on a rising edge with en = 1 and rst = 0 appear on the outputs right after that edge.
- Verdict: out <= (a & b) | (a & c) | (b & c).
  - Truth table a b c -> out: 000->0, 001->0, 010->0, 011->1, 100->0, 101->1, 110->1, 111->1.
- Tally: votes <= a + b + c, zero-extended to 2 bits; no overflow is possible (max 3).
- unanimous <= 1 for inputs 000 and 111; 0 otherwise.
- dissent (only on a 2-vs-1 split; otherwise 000):
  - 3'b100 when A is the minority (011, 100).
  - 3'b010 when B is the minority (010, 101).
  - 3'b001 when C is the minority (001, 110).
  - At most one bit is ever set.
- pass_cnt:
  - Increments by 1 on each enabled edge where the new verdict is 1.
  - Saturates at 2^CNT_W - 1 and holds there; never wraps.
  - Holds on enabled edges with verdict 0.
- en = 0: all outputs hold their previous values; inputs are ignored.
- Invariants:
  - out == (votes >= 2) at all times.
  - unanimous == (votes == 0 || votes == 3), except while holding the reset state (votes = 0, unanimous = 0).
- No combinational path from inputs to outputs. Inputs are synchronous to clk; this block has no synchronizers.

Test Plan:
1. Reset: drive rst = 1 for 2 cycles with a = b = c = 1 -> all outputs 0. Release rst, en = 1 -> next edge: out = 1, votes = 3, unanimous = 1, dissent = 000, pass_cnt = 1.
2. Exhaustive sweep, en = 1, one combination per cycle in order 000..111:
   - out: 0, 0, 0, 1, 0, 1, 1, 1.
   - votes: 0, 1, 1, 2, 1, 2, 2, 3.
   - dissent: 000, 001, 010, 100, 100, 010, 001, 000.
   - pass_cnt ends at 4 (from 0).
3. Enable hold: after abc = 110 is registered (out = 1), set en = 0 and abc = 000 for 5 cycles -> outputs unchanged, pass_cnt unchanged. Set en = 1 -> out = 0, votes = 0, unanimous = 1.
4. Saturation with CNT_W = 3: hold abc = 111, en = 1 for 10 cycles -> pass_cnt counts 1..7, then stays at 7.
5. Mid-operation reset: while pass_cnt = 5 and abc = 011, assert rst for 1 cycle -> all outputs 0 on that edge. The following enabled edge gives out = 1, pass_cnt = 1.
6. Reset priority: assert rst = 1 with en = 0 -> outputs still clear to 0.

Source files
------------

// File: rtl/judge3_vote_if.sv
// Voter inputs and registered verdict bundle for judge3_vote.
// The master drives the votes and sample enable; the slave (the judge) returns the verdict and side info.
interface judge3_vote_if #(
  parameter int CNT_W = 8
);
  logic             en;
  logic             a;
  logic             b;
  logic             c;
  logic             out;
  logic [1:0]       votes;
  logic             unanimous;
  logic [2:0]       dissent;
  logic [CNT_W-1:0] pass_cnt;

  modport master (
    output en, a, b, c,
    input  out, votes, unanimous, dissent, pass_cnt
  );

  modport slave (
    input  en, a, b, c,
    output out, votes, unanimous, dissent, pass_cnt
  );
endinterface

// File: rtl/judge3_vote.sv
// Registered 2-of-3 majority judge with tally, unanimity, one-hot dissenter and saturating pass counter.
// All outputs come straight from flops, so there is no combinational path from the votes to the outputs.
module judge3_vote #(
  parameter int CNT_W = 8
) (
  input  logic          clk,
  input  logic          rst,
  judge3_vote_if.slave  bus
);

  logic             verdict;
  logic [1:0]       tally;
  logic             all_same;
  logic [2:0]       minority;
  logic [CNT_W-1:0] cnt_next;

  logic             out_q;
  logic [1:0]       votes_q;
  logic             unanimous_q;
  logic [2:0]       dissent_q;
  logic [CNT_W-1:0] pass_cnt_q;

  assign verdict  = (bus.a & bus.b) | (bus.a & bus.c) | (bus.b & bus.c);
  assign tally    = {1'b0, bus.a} + {1'b0, bus.b} + {1'b0, bus.c};
  assign all_same = (bus.a == bus.b) && (bus.b == bus.c);

  // The lone voter on a 2-vs-1 split is flagged, whether it voted yes or no.
  always_comb begin
    // NOTE: assign a default before the case so no path leaves minority unassigned (no latch).
    minority = 3'b000;
    case ({bus.a, bus.b, bus.c})
      3'b011, 3'b100: minority = 3'b100;
      3'b010, 3'b101: minority = 3'b010;
      3'b001, 3'b110: minority = 3'b001;
      default:        minority = 3'b000;
    endcase
  end

  assign cnt_next = (verdict && (pass_cnt_q != '1)) ? pass_cnt_q + CNT_W'(1) : pass_cnt_q;

  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments for every register; rst wins over en and clears all state on the same edge.
    if (rst) begin
      out_q       <= 1'b0;
      votes_q     <= 2'd0;
      unanimous_q <= 1'b0;
      dissent_q   <= 3'b000;
      pass_cnt_q  <= '0;
    end else if (bus.en) begin
      out_q       <= verdict;
      votes_q     <= tally;
      unanimous_q <= all_same;
      dissent_q   <= minority;
      pass_cnt_q  <= cnt_next;
    end
  end

  assign bus.out       = out_q;
  assign bus.votes     = votes_q;
  assign bus.unanimous = unanimous_q;
  assign bus.dissent   = dissent_q;
  assign bus.pass_cnt  = pass_cnt_q;

endmodule

// File: tb/tb_judge3_vote.sv
// Self-checking bench for judge3_vote: directed plan plus random votes against a counting reference model.
// Two instances run in lockstep, one with an 8-bit and one with a 3-bit pass counter.
module tb_judge3_vote;

  logic clk;
  logic rst;

  judge3_vote_if #(.CNT_W(8)) bus8 ();
  judge3_vote_if #(.CNT_W(3)) bus3 ();

  judge3_vote #(.CNT_W(8)) dut8 (.clk(clk), .rst(rst), .bus(bus8));
  judge3_vote #(.CNT_W(3)) dut3 (.clk(clk), .rst(rst), .bus(bus3));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference state, derived from vote counting rather than gate equations.
  logic       m_out;
  logic [1:0] m_votes;
  logic       m_unan;
  logic [2:0] m_dissent;
  int         m_cnt8;
  int         m_cnt3;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_update(input logic r, input logic e, input logic [2:0] abc);
    int n;
    if (r) begin
      m_out = 1'b0; m_votes = 2'd0; m_unan = 1'b0; m_dissent = 3'b000;
      m_cnt8 = 0; m_cnt3 = 0;
    end else if (e) begin
      n = int'(abc[2]) + int'(abc[1]) + int'(abc[0]);
      m_votes   = 2'(n);
      m_out     = (n >= 2);
      m_unan    = (n == 0) || (n == 3);
      // With one yes the yes-voter is the minority; with two yes the no-voter is.
      m_dissent = (n == 1) ? abc : (n == 2) ? ~abc : 3'b000;
      if (m_out) begin
        m_cnt8 = (m_cnt8 + 1 > 255) ? 255 : m_cnt8 + 1;
        m_cnt3 = (m_cnt3 + 1 > 7)   ? 7   : m_cnt3 + 1;
      end
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, ".out"},       32'(bus8.out),       32'(m_out));
    check({tag, ".votes"},     32'(bus8.votes),     32'(m_votes));
    check({tag, ".unanimous"}, 32'(bus8.unanimous), 32'(m_unan));
    check({tag, ".dissent"},   32'(bus8.dissent),   32'(m_dissent));
    check({tag, ".cnt8"},      32'(bus8.pass_cnt),  32'(m_cnt8));
    check({tag, ".out3"},      32'(bus3.out),       32'(m_out));
    check({tag, ".dissent3"},  32'(bus3.dissent),   32'(m_dissent));
    check({tag, ".cnt3"},      32'(bus3.pass_cnt),  32'(m_cnt3));
  endtask

  // Drive one cycle of stimulus, let the edge happen, then compare 1 time unit later.
  task automatic step(input string tag, input logic r, input logic e, input logic [2:0] abc);
    rst = r;
    bus8.en = e; bus8.a = abc[2]; bus8.b = abc[1]; bus8.c = abc[0];
    bus3.en = e; bus3.a = abc[2]; bus3.b = abc[1]; bus3.c = abc[0];
    @(posedge clk);
    model_update(r, e, abc);
    #1;
    check_all(tag);
  endtask

  initial begin
    logic [7:0]  out_tbl;
    logic [15:0] votes_tbl;
    logic [23:0] dis_tbl;
    logic [2:0]  rabc;
    logic        ren;
    logic        rrst;

    out_tbl   = 8'b1110_1000;
    votes_tbl = {2'd3, 2'd2, 2'd2, 2'd1, 2'd2, 2'd1, 2'd1, 2'd0};
    dis_tbl   = {3'b000, 3'b001, 3'b010, 3'b100, 3'b100, 3'b010, 3'b001, 3'b000};

    m_out = 1'b0; m_votes = 2'd0; m_unan = 1'b0; m_dissent = 3'b000;
    m_cnt8 = 0; m_cnt3 = 0;
    rst = 1'b1;
    bus8.en = 1'b0; bus8.a = 1'b0; bus8.b = 1'b0; bus8.c = 1'b0;
    bus3.en = 1'b0; bus3.a = 1'b0; bus3.b = 1'b0; bus3.c = 1'b0;

    // Reset with all-yes votes pending, then the first enabled edge.
    step("reset0", 1'b1, 1'b1, 3'b111);
    step("reset1", 1'b1, 1'b1, 3'b111);
    check("reset.out_zero", 32'(bus8.out), 32'd0);
    check("reset.cnt_zero", 32'(bus8.pass_cnt), 32'd0);
    step("first", 1'b0, 1'b1, 3'b111);
    check("first.out", 32'(bus8.out), 32'd1);
    check("first.votes", 32'(bus8.votes), 32'd3);
    check("first.unanimous", 32'(bus8.unanimous), 32'd1);
    check("first.cnt", 32'(bus8.pass_cnt), 32'd1);

    // Exhaustive sweep from a cleared counter.
    step("sweep_rst", 1'b1, 1'b0, 3'b000);
    for (int i = 0; i < 8; i++) begin
      step("sweep", 1'b0, 1'b1, 3'(i));
      check("sweep.out_tbl", 32'(bus8.out), 32'(out_tbl[i]));
      check("sweep.votes_tbl", 32'(bus8.votes), 32'(votes_tbl[2*i +: 2]));
      check("sweep.dissent_tbl", 32'(bus8.dissent), 32'(dis_tbl[3*i +: 3]));
    end
    check("sweep.cnt_end", 32'(bus8.pass_cnt), 32'd4);

    // Enable hold: outputs freeze while en is low.
    step("hold_load", 1'b0, 1'b1, 3'b110);
    for (int i = 0; i < 5; i++) begin
      step("hold", 1'b0, 1'b0, 3'b000);
      check("hold.out", 32'(bus8.out), 32'd1);
      check("hold.dissent", 32'(bus8.dissent), 32'b001);
      check("hold.cnt", 32'(bus8.pass_cnt), 32'd5);
    end
    step("hold_release", 1'b0, 1'b1, 3'b000);
    check("release.out", 32'(bus8.out), 32'd0);
    check("release.unanimous", 32'(bus8.unanimous), 32'd1);

    // Saturation of the 3-bit counter.
    step("sat_rst", 1'b1, 1'b1, 3'b000);
    for (int i = 0; i < 10; i++) begin
      step("sat", 1'b0, 1'b1, 3'b111);
      check("sat.cnt3", 32'(bus3.pass_cnt), (i + 1 > 7) ? 32'd7 : 32'(i + 1));
    end

    // Mid-operation reset.
    step("mid_rst0", 1'b1, 1'b1, 3'b000);
    for (int i = 0; i < 5; i++) step("mid_fill", 1'b0, 1'b1, 3'b111);
    check("mid.cnt5", 32'(bus8.pass_cnt), 32'd5);
    step("mid_rst", 1'b1, 1'b1, 3'b011);
    check("mid.cleared_cnt", 32'(bus8.pass_cnt), 32'd0);
    check("mid.cleared_out", 32'(bus8.out), 32'd0);
    step("mid_after", 1'b0, 1'b1, 3'b011);
    check("mid.after_cnt", 32'(bus8.pass_cnt), 32'd1);
    check("mid.after_dissent", 32'(bus8.dissent), 32'b100);

    // Reset wins over a low enable.
    step("prio_load", 1'b0, 1'b1, 3'b111);
    step("prio", 1'b1, 1'b0, 3'b111);
    check("prio.unanimous", 32'(bus8.unanimous), 32'd0);
    check("prio.votes", 32'(bus8.votes), 32'd0);

    // Random votes without reset, long enough to saturate the 8-bit counter.
    for (int i = 0; i < 900; i++) begin
      rabc = 3'($urandom_range(0, 7));
      ren  = ($urandom_range(0, 7) != 0);
      step("rand", 1'b0, ren, rabc);
    end
    // Random votes with occasional reset.
    for (int i = 0; i < 300; i++) begin
      rabc = 3'($urandom_range(0, 7));
      ren  = ($urandom_range(0, 3) != 0);
      rrst = ($urandom_range(0, 24) == 0);
      step("rand_rst", rrst, ren, rabc);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
